// File: rtl/fridge_compressor_scheduler.sv
// fridge_compressor_scheduler
//   Sequences the refrigerator compressor and defrost heater. The raw door
//   open/close pulses (I1/I0) and the temperature-high level (x) are
//   synchronised, and the door pulses are reduced to single-cycle edges. A
//   registered FSM (IDLE/COOL/HOLD/DEFROST) then enforces the compressor
//   minimum on and off times and inserts a defrost cycle once enough
//   compressor run time has accumulated.
//
//   Optional feature: define DOOR_ALARM_EN to build the door-left-open
//   alarm counter. Without it, door_alarm is tied low and no counter exists.
//
//   Counter semantics: on_cnt, off_cnt and dcnt hold the number of cycles
//   already completed in the current state. They read 0 in the first cycle
//   of a state and clear whenever that state is left, so they always start
//   from 0 on the next entry.

module fridge_compressor_scheduler #(
  parameter int CNT_W             = 16,
  parameter int MIN_ON            = 4,
  parameter int MIN_OFF           = 3,
  parameter int DEFROST_INTERVAL  = 10,
  parameter int DEFROST_LEN       = 5,
  parameter int DOOR_ALARM_CYCLES = 6
) (
  input  logic       sync_clk,
  input  logic       reset,
  input  logic       I0,
  input  logic       I1,
  input  logic       x,
  output logic       compressor_on,
  output logic       defrost_on,
  output logic       Z,
  output logic       door_alarm,
  output logic [1:0] state
);

  // State encoding is visible on the state port, so the values are fixed.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COOL    = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_DEFROST = 2'd3;

  // Thresholds, pre-sized to the counter width.
  // The "-1" forms compare against cycles already completed, so the
  // cycle that satisfies the compare is the last one spent in the state.
  localparam logic [CNT_W-1:0] MIN_ON_LAST      = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] MIN_OFF_LAST     = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] DEFROST_LAST     = CNT_W'(DEFROST_LEN - 1);
  localparam logic [CNT_W-1:0] DEFROST_THRESH   = CNT_W'(DEFROST_INTERVAL);

  // Saturating increment shared by every counter in the block.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------------
  logic i0_s1, i0_s2, i0_s3;
  logic i1_s1, i1_s2, i1_s3;
  logic x_s1, x_s2;

  logic open_edge;
  logic close_edge;
  logic x_s;

  // Two-flop synchronisers for all asynchronous inputs; the third door flop
  // only exists to form the rising-edge detect.
  always_ff @(posedge sync_clk or posedge reset) begin
    if (reset) begin
      i0_s1 <= 1'b0;
      i0_s2 <= 1'b0;
      i0_s3 <= 1'b0;
      i1_s1 <= 1'b0;
      i1_s2 <= 1'b0;
      i1_s3 <= 1'b0;
      x_s1  <= 1'b0;
      x_s2  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the value its
      // predecessor held before the edge, which is what builds a real chain.
      i0_s1 <= I0;
      i0_s2 <= i0_s1;
      i0_s3 <= i0_s2;
      i1_s1 <= I1;
      i1_s2 <= i1_s1;
      i1_s3 <= i1_s2;
      x_s1  <= x;
      x_s2  <= x_s1;
    end
  end

  assign open_edge  = i1_s2 & ~i1_s3;
  assign close_edge = i0_s2 & ~i0_s3;
  assign x_s        = x_s2;

  // ---------------------------------------------------------------------------
  // Door status
  // ---------------------------------------------------------------------------
  logic z_next;

  // Next door status: an open edge wins over a simultaneous close edge.
  always_comb begin
    if (open_edge) begin
      z_next = 1'b1;
    end else if (close_edge) begin
      z_next = 1'b0;
    end else begin
      z_next = Z;
    end
  end

  // Door status register.
  always_ff @(posedge sync_clk or posedge reset) begin
    if (reset) begin
      Z <= 1'b0;
    end else begin
      Z <= z_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Compressor FSM
  // ---------------------------------------------------------------------------
  logic [1:0]       state_next;
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] off_cnt;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] run_acc;

  // Next-state decision. The door opening during COOL overrides the minimum
  // on time; DEFROST ignores both the door and the temperature flag.
  always_comb begin
    // NOTE: the default assignment up front means every path drives
    // state_next, so no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (run_acc >= DEFROST_THRESH) begin
          state_next = ST_DEFROST;
        end else if (x_s && !Z) begin
          state_next = ST_COOL;
        end
      end
      ST_COOL: begin
        if (Z) begin
          state_next = ST_HOLD;
        end else if (!x_s && (on_cnt >= MIN_ON_LAST)) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (off_cnt == MIN_OFF_LAST) begin
          state_next = ST_IDLE;
        end
      end
      ST_DEFROST: begin
        if (dcnt == DEFROST_LAST) begin
          state_next = ST_HOLD;
        end
      end
      default: begin
        state_next = ST_HOLD;
      end
    endcase
  end

  // State register and per-state cycle counters. Reset lands in HOLD so the
  // compressor always gets its rest period after power-up or a fault reset.
  always_ff @(posedge sync_clk or posedge reset) begin
    if (reset) begin
      state   <= ST_HOLD;
      on_cnt  <= '0;
      off_cnt <= '0;
      dcnt    <= '0;
    end else begin
      state   <= state_next;
      on_cnt  <= (state == ST_COOL    && state_next == ST_COOL)    ? sat_inc(on_cnt)  : '0;
      off_cnt <= (state == ST_HOLD    && state_next == ST_HOLD)    ? sat_inc(off_cnt) : '0;
      dcnt    <= (state == ST_DEFROST && state_next == ST_DEFROST) ? sat_inc(dcnt)    : '0;
    end
  end

  // Accumulated compressor run time; every COOL cycle counts, and a completed
  // defrost starts the accumulation over.
  always_ff @(posedge sync_clk or posedge reset) begin
    if (reset) begin
      run_acc <= '0;
    end else if (state == ST_COOL) begin
      run_acc <= sat_inc(run_acc);
    end else if (state == ST_DEFROST && state_next == ST_HOLD) begin
      run_acc <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Door-left-open alarm
  // ---------------------------------------------------------------------------
`ifdef DOOR_ALARM_EN
  logic [CNT_W-1:0] door_cnt;

  localparam logic [CNT_W-1:0] DOOR_ALARM_THRESH = CNT_W'(DOOR_ALARM_CYCLES);

  // Counts cycles with the door open, including the cycle Z rises; it
  // follows z_next so it clears on the same edge that clears Z.
  always_ff @(posedge sync_clk or posedge reset) begin
    if (reset) begin
      door_cnt <= '0;
    end else if (z_next) begin
      door_cnt <= sat_inc(door_cnt);
    end else begin
      door_cnt <= '0;
    end
  end

  assign door_alarm = (door_cnt >= DOOR_ALARM_THRESH);
`else
  assign door_alarm = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output decode from registered state
  // ---------------------------------------------------------------------------
  assign compressor_on = (state == ST_COOL);
  assign defrost_on    = (state == ST_DEFROST);

endmodule
